// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, runs a req/ack read of instruction memory,
// captures the word and pulses IRWrite; handles redirects and faults.
// Ports:
//   Clk, Reset        clock, async active-low reset
//   Fetch, Redirect   control pulses; RedirectAddr is the branch target
//   MemReq/MemAddr    registered read request and address
//   MemRdata/MemAck   read data and acknowledge
//   Instruction       last fetched word; IRWrite pulses when it updates
//   Busy              request outstanding
//   FetchFault        pulse on misaligned fetch or memory timeout
//   PC                current program counter
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Fetch,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic [31:0] Instruction,
  output logic        IRWrite,
  output logic        Busy,
  output logic        FetchFault,
  output logic [31:0] PC
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        irw_q, irw_d;
  logic        fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic [31:0] fetch_addr;
  logic        tgt_v;
  logic [31:0] tgt;

  // A redirect arriving in the completing cycle wins over an older one.
  assign fetch_addr = Redirect ? RedirectAddr : pc_q;
  assign tgt_v      = pend_q | Redirect;
  assign tgt        = Redirect ? RedirectAddr : pend_addr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    irw_d       = 1'b0;
    fault_d     = 1'b0;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      IDLE: begin
        if (Fetch) begin
          pc_d = fetch_addr;
          if (fetch_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = fetch_addr;
            cnt_d   = 8'd0;
          end
        end else if (Redirect) begin
          pc_d = RedirectAddr;
        end
      end
      REQ: begin
        if (MemAck) begin
          instr_d = MemRdata;
          irw_d   = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
          pc_d    = tgt_v ? tgt : pc_q + 32'd4;
          pend_d  = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q == TO_LAST) begin
          // This is the TIMEOUT-th cycle without an ack.
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = IDLE;
          if (tgt_v) pc_d = tgt;
          pend_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (Redirect) begin
            pend_d      = 1'b1;
            pend_addr_d = RedirectAddr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= 32'd0;
      instr_q     <= 32'd0;
      irw_q       <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= 8'd0;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      irw_q       <= irw_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign MemReq      = req_q;
  assign MemAddr     = addr_q;
  assign Instruction = instr_q;
  assign IRWrite     = irw_q;
  assign FetchFault  = fault_q;
  assign Busy        = (state_q == REQ);
  assign PC          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: random fetches against a
// transaction-level PC/instruction model and a programmable-wait memory.
module tb_instruction_fetch_unit;

  localparam int TO = 15;

  logic        Clk;
  logic        Reset;
  logic        Fetch;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRdata;
  logic        MemAck;
  logic [31:0] Instruction;
  logic        IRWrite;
  logic        Busy;
  logic        FetchFault;
  logic [31:0] PC;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (TO)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Fetch       (Fetch),
    .Redirect    (Redirect),
    .RedirectAddr(RedirectAddr),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemRdata    (MemRdata),
    .MemAck      (MemAck),
    .Instruction (Instruction),
    .IRWrite     (IRWrite),
    .Busy        (Busy),
    .FetchFault  (FetchFault),
    .PC          (PC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          fault;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int seen   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  // memory responder controls
  logic [31:0] exp_addr;
  logic [31:0] cur_data;
  int          wait_n = 0;
  bit          force_ack = 1'b0;
  int          addr_bad = 0;
  int          last_len = 0;
  int          len_run = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endfunction

  // memory: acks on the (wait_n+1)-th cycle of a request
  initial begin
    int k;
    k = 0;
    MemAck = 1'b0;
    MemRdata = 32'd0;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset && MemReq) begin
        k++;
        MemAck   = (k > wait_n);
        MemRdata = MemAck ? cur_data : 32'hDEAD_BEEF;
      end else begin
        k = 0;
        MemAck   = force_ack;
        MemRdata = cur_data;
      end
    end
  end

  // request length, address stability and Busy tracking
  initial begin
    forever begin
      @(negedge Clk);
      if (Busy !== MemReq) addr_bad++;
      if (MemReq) begin
        len_run++;
        if (MemAddr !== exp_addr) addr_bad++;
      end else if (len_run != 0) begin
        last_len = len_run;
        len_run  = 0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset && (IRWrite || FetchFault)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event irwrite=%b fault=%b t=%0t",
                   IRWrite, FetchFault, $time);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, IRWrite, FetchFault},
              e.fault ? 32'd1 : 32'd2);
          chk("instruction", Instruction, e.instr);
          chk("pc", PC, e.pc);
        end
        seen++;
      end
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      #1;
      if (seen == issued) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout seen=%0d required=%0d", seen, issued);
      seen = issued;
    end
  endtask

  task automatic idle_redirect(input logic [31:0] ra);
    Redirect = 1'b1;
    RedirectAddr = ra;
    @(posedge Clk);
    #1;
    Redirect = 1'b0;
    m_pc = ra;
    chk("pc_idle_redirect", PC, m_pc);
  endtask

  // rj1/rj2: REQ-cycle index of a redirect (-1 = none); fj: stray Fetch
  task automatic fetch_txn(input bit wr, input logic [31:0] ra,
                           input int w,
                           input int rj1, input logic [31:0] rd1,
                           input int rj2, input logic [31:0] rd2,
                           input int fj, input logic [31:0] data);
    logic [31:0] a;
    logic [31:0] tgt;
    bit          tv;
    bit          done_ok;
    int          lim;
    int          exp_len;
    int          r1, r2;
    a = wr ? ra : m_pc;
    done_ok = (w < TO);
    lim = done_ok ? w : TO - 1;
    r1 = (rj1 < lim) ? rj1 : -1;
    r2 = (rj2 < lim && rj2 > r1) ? rj2 : -1;
    tv = (r1 >= 0) || (r2 >= 0);
    tgt = (r2 >= 0) ? rd2 : rd1;
    exp_len = done_ok ? w + 1 : TO;
    exp_addr = a;
    wait_n = w;
    cur_data = data;
    addr_bad = 0;
    last_len = 0;
    if (a[1:0] != 2'b00) begin
      m_pc = a;
      exp_q.push_back('{1'b1, m_instr, m_pc});
    end else if (done_ok) begin
      m_instr = data;
      m_pc = tv ? tgt : a + 32'd4;
      exp_q.push_back('{1'b0, m_instr, m_pc});
    end else begin
      m_pc = tv ? tgt : a;
      exp_q.push_back('{1'b1, m_instr, m_pc});
    end
    issued++;
    Fetch = 1'b1;
    Redirect = wr;
    RedirectAddr = ra;
    @(posedge Clk);
    #1;
    Fetch = 1'b0;
    Redirect = 1'b0;
    if (a[1:0] == 2'b00) begin
      chk("req_latency", {31'd0, MemReq}, 32'd1);
      for (int j = 0; j < lim; j++) begin
        Redirect = (j == r1) || (j == r2);
        RedirectAddr = (j == r2) ? rd2 : rd1;
        Fetch = (j == fj);
        @(posedge Clk);
        #1;
      end
      Redirect = 1'b0;
      Fetch = 1'b0;
    end else begin
      chk("no_req_misaligned", {31'd0, MemReq}, 32'd0);
    end
    wait_done();
    if (a[1:0] == 2'b00) begin
      chk("req_len", last_len, exp_len);
      chk("addr_busy_stable", addr_bad, 0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd1;
    logic [31:0] rd2;
    int w;
    Reset = 1'b0;
    Fetch = 1'b0;
    Redirect = 1'b0;
    RedirectAddr = 32'd0;
    cur_data = 32'd0;
    exp_addr = 32'd0;
    m_pc = 32'd0;
    m_instr = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc", PC, 32'd0);
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_fault", {31'd0, FetchFault}, 32'd0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // directed cases
    fetch_txn(0, 0, 0, -1, 0, -1, 0, -1, 32'h8C22_0004);
    fetch_txn(0, 0, 3, -1, 0, -1, 0, -1, 32'h1234_5678);
    fetch_txn(0, 0, 255, -1, 0, -1, 0, -1, 32'hFFFF_0000);
    idle_redirect(32'h20);
    fetch_txn(0, 0, 4, 1, 32'h100, -1, 0, -1, 32'hABCD_0001);
    fetch_txn(0, 0, 1, -1, 0, -1, 0, -1, 32'hABCD_0002);
    fetch_txn(1, 32'h202, 0, -1, 0, -1, 0, -1, 32'd0);
    fetch_txn(1, 32'h200, 2, -1, 0, -1, 0, -1, 32'hABCD_0003);
    fetch_txn(0, 0, 6, 0, 32'h300, 3, 32'h400, 1, 32'hABCD_0004);
    fetch_txn(0, 0, 255, 2, 32'h500, -1, 0, 4, 32'hABCD_0005);
    idle_redirect(32'hFFFF_FFFC);
    fetch_txn(0, 0, 0, -1, 0, -1, 0, -1, 32'hABCD_0006);
    chk("pc_wrap", m_pc, 32'd0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      ra = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
      rd1 = $urandom() & 32'hFFFF_FFFC;
      rd2 = $urandom() & 32'hFFFF_FFFC;
      w = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) idle_redirect($urandom() & 32'hFFFF_FFFC);
      fetch_txn($urandom_range(0, 3) == 0, ra, w,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1,
                rd1,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1,
                rd2,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                $urandom());
    end

    // reset in the middle of a request
    if (m_pc[1:0] != 2'b00) idle_redirect(32'h40);
    exp_addr = m_pc;
    wait_n = 255;
    Fetch = 1'b1;
    @(posedge Clk);
    #1;
    Fetch = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("mid_rst_memaddr", MemAddr, 32'd0);
    chk("mid_rst_instr", Instruction, 32'd0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_pc", PC, 32'd0);
    m_pc = 32'd0;
    m_instr = 32'd0;
    force_ack = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("stray_ack_irwrite", {31'd0, IRWrite}, 32'd0);
    chk("stray_ack_instr", Instruction, 32'd0);
    force_ack = 1'b0;
    @(posedge Clk);
    #1;
    fetch_txn(0, 0, 2, -1, 0, -1, 0, -1, 32'hC0DE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side writer for the multi-cycle CPU's instruction register.
- Owns the PC and runs a request/acknowledge read against instruction memory.
- Captures the returned word and pulses IRWrite for one cycle so the register latches the word, split into fields.
- Handles branch/jump redirects, misaligned PCs and memory timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
TIMEOUT, 15, max cycles MemReq may stay high without MemAck before fault (1..255)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Fetch  input  1  single-cycle request from control FSM to fetch at current PC
Redirect  input  1  load PC from RedirectAddr (branch/jump)
RedirectAddr  input  32  redirect target
MemReq  output  1  memory read request, registered
MemAddr  output  32  read address, stable while MemReq high
MemRdata  input  32  read data, valid when MemAck high
MemAck  input  1  memory acknowledge, sampled only while MemReq high
Instruction  output  32  last fetched word, held until next successful fetch
IRWrite  output  1  one-cycle pulse, Instruction valid this cycle
Busy  output  1  high in REQ state
FetchFault  output  1  one-cycle pulse on misalignment or timeout
PC  output  32  current program counter

Behaviour:
- Reset (Reset=0, async): PC=RESET_PC; MemReq=0; MemAddr=0; Instruction=0; IRWrite=0; Busy=0; FetchFault=0; timeout counter=0; pending redirect cleared; state=IDLE.
- States: IDLE, REQ. IRWrite and FetchFault are registered pulses and need no separate states.
- IDLE, Redirect=1, Fetch=0: PC<=RedirectAddr. No request.
- IDLE, Fetch=1: effective address A = Redirect ? RedirectAddr : PC. Redirect and Fetch in the same cycle fetches from the redirect target.
  - A[1:0]!=0: FetchFault=1 next cycle; PC<=A; no request; stay IDLE.
  - Otherwise: next cycle MemReq=1, MemAddr=A, PC=A, Busy=1, counter=0, state=REQ.
- REQ, each cycle:
  - MemAck=0: counter++.
  - MemAck=1: next cycle Instruction<=MemRdata, IRWrite=1, MemReq=0, Busy=0, state=IDLE, PC<=PC+4 (mod 2^32, wraps FFFF_FFFC->0000_0000).
  - Pending redirect at completion: PC<=pending target instead of PC+4; pending cleared.
- Timeout: counter reaches TIMEOUT with no MemAck. Next cycle MemReq=0, FetchFault=1, Busy=0, state=IDLE; PC unchanged; Instruction unchanged; no IRWrite.
- Redirect during REQ: latched as pending; MemAddr not disturbed. A later redirect overwrites an earlier pending one. Pending is also applied on timeout, loading PC.
- Fetch during REQ: ignored, not queued.
- MemAck outside REQ: ignored.
- MemAddr and MemReq never change mid-request except on ack or timeout.
- Latency: Fetch at cycle N -> MemReq at N+1. Ack sampled at cycle M -> IRWrite at M+1. Zero-wait memory (ack at N+1) gives IRWrite at N+2.
- Back-to-back: Fetch in the same cycle IRWrite pulses is accepted, since state is already IDLE, and uses the updated PC.
- Reset asserted mid-request: all outputs return to reset values immediately; the in-flight ack is discarded.

Test Plan:
- Reset release, RESET_PC=0. Fetch pulse; memory acks 1 cycle after MemReq with 0x8C220004 -> MemAddr=0; IRWrite one cycle; Instruction=0x8C220004; PC=4.
- Memory wait 3 cycles, TIMEOUT=15 -> MemReq high exactly 4 cycles; MemAddr constant; single IRWrite; PC+4.
- No ack, TIMEOUT=15 -> MemReq drops after 15 non-ack cycles; FetchFault one pulse; PC, Instruction unchanged; no IRWrite.
- Redirect 0x100 during REQ at PC=0x20 -> fetch completes from 0x20; PC=0x100 (not 0x24). Next Fetch -> MemAddr=0x100.
- Fetch+Redirect 0x202 in IDLE -> FetchFault; no MemReq; PC=0x202. Fetch+Redirect 0x200 -> MemAddr=0x200.
- PC=0xFFFFFFFC fetch completes -> PC=0. Reset pulled low while MemReq=1 -> all outputs zero; later ack ignored.
